riscv_v_seq_div: RTL and testbench
==================================

RISCV_V_SEQ_DIV -- requirements
Module: riscv_v_seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (even, >=4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  dividend/divisor/is_signed valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-006 SHALL have port A  input  WIDTH  dividend.
REQ-007 SHALL have port B  input  WIDTH  divisor.
REQ-008 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port flush  input  1  abort any in-flight operation.
REQ-010 SHALL have port out_valid  output  1  Q/R valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts Q/R.
REQ-012 SHALL have port Q  output  WIDTH  quotient.
REQ-013 SHALL have port R  output  WIDTH  remainder.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE) and no combinational path from in_valid to in_ready.
REQ-015 SHALL accept an operation when in_valid & in_ready; A, B, is_signed captured into internal registers that cycle; later input changes ignored.
REQ-016 On accept with B!=0 and no overflow: IDLE->CALC, iteration counter loaded with WIDTH-1.
REQ-017 SHALL use radix-2 restoring division on magnitudes: each CALC cycle shifts partial remainder left by one, brings in next dividend bit MSB-first, subtracts |B| if result non-negative, sets one quotient bit.
REQ-018 CALC->DONE when counter==0 after its iteration; exactly WIDTH CALC cycles; out_valid rises WIDTH+1 cycles after the accept edge.
REQ-019 Magnitudes: when is_signed and operand MSB=1, use two's complement; else raw value; internal datapath WIDTH+1 bits for remainder/subtract.
REQ-020 Sign fix-up applied entering DONE: Q negated when is_signed and sign(A)!=sign(B); R takes sign of A (negated when is_signed and A negative).
REQ-021 Divide by zero (B==0): IDLE->DONE directly, out_valid one cycle after accept, Q = all ones, R = A (signed or unsigned).
REQ-022 Signed overflow (is_signed, A = most negative, B = all ones): IDLE->DONE directly, Q = A, R = 0, latency one cycle.
REQ-023 In DONE: out_valid=1; Q/R held stable while out_ready=0; DONE->IDLE on out_ready=1; no new accept in that same cycle.
REQ-024 flush=1 in any state SHALL force IDLE next cycle, deassert out_valid, discard result; flush has priority over accept and out_ready; in_valid during flush cycle not accepted.
REQ-025 Q, R SHALL hold last value when out_valid=0 (not required meaningful).

Reset
REQ-026 rst_n=0 at a rising edge SHALL set state=IDLE, counter=0, out_valid=0, Q=0, R=0, all operand/partial registers=0, regardless of in-flight operation.
REQ-027 in_ready SHALL be 1 first cycle after rst_n deasserts; reset has priority over flush and all handshakes.

Verification (WIDTH=8)
REQ-028 Unsigned A=100, B=7 -> Q=14 (0x0E), R=2, out_valid exactly 9 cycles after accept.
REQ-029 Signed A=0xF9(-7), B=0x02 -> Q=0xFD(-3), R=0xFF(-1); signed A=0x07, B=0xFE(-2) -> Q=0xFD, R=0x01.
REQ-030 A=0x25, B=0x00 (both is_signed values) -> Q=0xFF, R=0x25, out_valid 1 cycle after accept; signed A=0x80, B=0xFF -> Q=0x80, R=0x00, 1 cycle.
REQ-031 Unsigned 0xFF/0x01 result with out_ready low 5 cycles -> out_valid and Q=0xFF, R=0x00 stable all 5 cycles; in_ready=0 until cycle after out_ready=1.
REQ-032 flush asserted 3 cycles into CALC -> IDLE next cycle, out_valid never rises, next op 0x64/0x0A -> Q=0x0A, R=0x00.
REQ-033 rst_n low 4 cycles into CALC -> out_valid=0, Q=R=0, in_ready=1 first cycle after release; back-to-back ops 200/13 then 13/200 -> Q=15,R=5 then Q=0,R=13.

Source files
------------

// File: rtl/riscv_v_seq_div.sv
// Sequential radix-2 restoring divider for signed/unsigned integer division.
// One quotient bit per CALC cycle on operand magnitudes, sign fix-up on the
// way into DONE. Divide-by-zero and signed overflow bypass CALC entirely.
//
// state | meaning
// IDLE  | ready for a new operation (in_ready = 1)
// CALC  | iterating, one quotient bit per cycle, WIDTH cycles total
// DONE  | result valid on Q/R, waiting for out_ready

module riscv_v_seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;      // dividend magnitude, quotient bits shift in at LSB
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [WIDTH-1:0] rem_q;      // partial remainder, always < dvs_q between steps
    logic             neg_q_q;
    logic             neg_r_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             sgn_ovf;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign a_neg    = is_signed & A[WIDTH-1];
    assign b_neg    = is_signed & B[WIDTH-1];
    assign a_mag    = a_neg ? ('0 - A) : A;
    assign b_mag    = b_neg ? ('0 - B) : B;
    assign div_zero = (B == '0);
    assign sgn_ovf  = is_signed & (A == MOST_NEG) & (B == '1);

    // The shifted remainder needs WIDTH+1 bits, but whenever the subtraction
    // is taken the result is below the divisor, so a WIDTH-bit subtract is exact.
    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
    assign rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
    assign rem_nxt   = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
    assign quo_nxt   = {dvd_q[WIDTH-2:0], rem_ge};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign R         = r_q;

    // Control FSM and datapath: reset, then flush, then normal handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (div_zero) begin
                            q_q         <= '1;
                            r_q         <= A;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (sgn_ovf) begin
                            q_q         <= A;
                            r_q         <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            dvd_q   <= a_mag;
                            dvs_q   <= b_mag;
                            rem_q   <= '0;
                            neg_q_q <= a_neg ^ b_neg;
                            neg_r_q <= a_neg;
                            cnt_q   <= CNT_INIT;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd_q <= quo_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        q_q         <= neg_q_q ? ('0 - quo_nxt) : quo_nxt;
                        r_q         <= neg_r_q ? ('0 - rem_nxt) : rem_nxt;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_v_seq_div.sv
// Directed bench for riscv_v_seq_div at WIDTH=8 with hand-computed results.

module tb_riscv_v_seq_div;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       is_signed;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Q;
    logic [7:0] R;

    int tests = 0;
    int fails = 0;

    riscv_v_seq_div #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .is_signed (is_signed),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, return just after its accept edge; inputs are
    // scrambled afterwards so a design that keeps sampling them goes wrong.
    task automatic issue(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        A         = a;
        B         = b;
        is_signed = s;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        A         = 8'hAA;
        B         = 8'h55;
        is_signed = ~s;
    endtask

    // Latency counts the accept edge as cycle 1.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk_int({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] eq, input logic [7:0] er, input int elat);
        issue(tag, a, b, s);
        wait_valid(tag, elat);
        chk8({tag, "_Q"}, Q, eq);
        chk8({tag, "_R"}, R, er);
        tick();
        chk1({tag, "_drained"}, out_valid, 1'b0);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = 8'h00;
        B         = 8'h00;
        is_signed = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk1("rst_out_valid", out_valid, 1'b0);
        chk8("rst_Q", Q, 8'h00);
        chk8("rst_R", R, 8'h00);
        rst_n = 1'b1;
        chk1("rst_release_in_ready", in_ready, 1'b1);

        run("u100_7",  8'd100, 8'd7,  1'b0, 8'h0E, 8'h02, 9);
        run("s_m7_2",  8'hF9,  8'h02, 1'b1, 8'hFD, 8'hFF, 9);
        run("s_7_m2",  8'h07,  8'hFE, 1'b1, 8'hFD, 8'h01, 9);
        run("dz_u",    8'h25,  8'h00, 1'b0, 8'hFF, 8'h25, 1);
        run("dz_s",    8'h25,  8'h00, 1'b1, 8'hFF, 8'h25, 1);
        run("ovf_s",   8'h80,  8'hFF, 1'b1, 8'h80, 8'h00, 1);
        run("s_m128_2", 8'h80, 8'h02, 1'b1, 8'hC0, 8'h00, 9);
        run("u_80_ff", 8'h80,  8'hFF, 1'b0, 8'h00, 8'h80, 9);

        // Consumer stalls for five cycles
        out_ready = 1'b0;
        issue("stall", 8'hFF, 8'h01, 1'b0);
        wait_valid("stall", 9);
        for (int i = 0; i < 5; i++) begin
            chk1("stall_out_valid", out_valid, 1'b1);
            chk8("stall_Q", Q, 8'hFF);
            chk8("stall_R", R, 8'h00);
            chk1("stall_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk1("stall_release_in_ready", in_ready, 1'b0);
        tick();
        chk1("stall_done_out_valid", out_valid, 1'b0);
        chk1("stall_done_in_ready", in_ready, 1'b1);

        // Flush three cycles into CALC
        issue("flush_calc", 8'h64, 8'h07, 1'b0);
        repeat (3) tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        A        = 8'h05;
        B        = 8'h00;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk1("flush_calc_in_ready", in_ready, 1'b1);
        chk1("flush_calc_out_valid", out_valid, 1'b0);
        seen = 0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk_int("flush_calc_no_result", seen, 0);

        // Flush wins over an accept in IDLE (a divide-by-zero would finish next cycle)
        flush     = 1'b1;
        in_valid  = 1'b1;
        A         = 8'h05;
        B         = 8'h00;
        is_signed = 1'b0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk1("flush_idle_out_valid", out_valid, 1'b0);
        chk1("flush_idle_in_ready", in_ready, 1'b1);
        tick();
        chk1("flush_idle_still_idle", out_valid, 1'b0);

        run("post_flush", 8'h64, 8'h0A, 1'b0, 8'h0A, 8'h00, 9);

        // Leave non-zero Q/R behind, then reset in the middle of CALC
        run("pre_rst", 8'h25, 8'h00, 1'b0, 8'hFF, 8'h25, 1);
        issue("rst_calc", 8'd200, 8'd13, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        chk1("rst_calc_out_valid", out_valid, 1'b0);
        chk8("rst_calc_Q", Q, 8'h00);
        chk8("rst_calc_R", R, 8'h00);
        rst_n = 1'b1;
        chk1("rst_calc_in_ready", in_ready, 1'b1);
        seen = 0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk_int("rst_calc_no_result", seen, 0);

        run("b2b_200_13", 8'd200, 8'd13,  1'b0, 8'd15, 8'd5,  9);
        run("b2b_13_200", 8'd13,  8'd200, 1'b0, 8'd0,  8'd13, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
